endpoint_fifo: RTL and testbench

Parametrised byte FIFO for USB endpoint payloads, sitting between the AHB-Lite slave, the USB RX/TX packet engines and the protocol controller. It generalises the fixed 64-byte endpoint buffer with the following additions:
- configurable depth and AHB word width;
- true circular wrap-around with concurrent read and write;
- all-or-nothing multi-byte transfers;
- full/empty flags and sticky overflow/underflow error flags.

---
 rtl/endpoint_fifo_pkg.sv | 13 +
 rtl/fifo_ptr_ctrl.sv | 69 ++++++
 rtl/endpoint_fifo.sv | 97 +++++++++
 tb/tb_endpoint_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/endpoint_fifo_pkg.sv
// Shared constants and helpers for the endpoint byte FIFO.
// data_size encodes a transfer length as bytes minus one.
package endpoint_fifo_pkg;

  localparam logic [3:0] SIZE_BYTE = 4'd0;
  localparam logic [3:0] SIZE_HALF = 4'd1;
  localparam logic [3:0] SIZE_WORD = 4'd3;

  function automatic logic [4:0] bytes_of(input logic [3:0] size);
    return {1'b0, size} + 5'd1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and error-flag bookkeeping for the endpoint FIFO.
// Accept/drop decisions use only the pre-edge occupancy.
module fifo_ptr_ctrl #(
  parameter int DEPTH = 64,
  parameter int PTR_W = 6,
  parameter int OCC_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_wr_req,
  input  logic [OCC_W-1:0] i_wr_n,
  input  logic             i_rd_req,
  input  logic [OCC_W-1:0] i_rd_n,
  output logic             o_wr_ok,
  output logic             o_rd_ok,
  output logic [PTR_W-1:0] o_wptr,
  output logic [PTR_W-1:0] o_rptr,
  output logic [OCC_W-1:0] o_occupancy,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_full, r_empty, r_overflow, r_underflow;
  logic [OCC_W-1:0] w_space, w_occ_next;
  logic             w_flush;

  assign w_flush    = rst | i_clear;
  assign w_space    = DEPTH_C - r_occ;
  assign o_wr_ok    = i_wr_req & (i_wr_n <= w_space) & ~w_flush;
  assign o_rd_ok    = i_rd_req & (i_rd_n <= r_occ) & ~w_flush;
  assign w_occ_next = r_occ + (o_wr_ok ? i_wr_n : '0) - (o_rd_ok ? i_rd_n : '0);

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_occ       <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Truncation to PTR_W bits gives the modulo-DEPTH wrap.
      if (o_wr_ok) r_wptr <= r_wptr + PTR_W'(i_wr_n);
      if (o_rd_ok) r_rptr <= r_rptr + PTR_W'(i_rd_n);
      r_occ   <= w_occ_next;
      r_full  <= (w_occ_next == DEPTH_C);
      r_empty <= (w_occ_next == '0);
      if (i_wr_req && !o_wr_ok) r_overflow <= 1'b1;
      if (i_rd_req && !o_rd_ok) r_underflow <= 1'b1;
    end
  end

  assign o_wptr      = r_wptr;
  assign o_rptr      = r_rptr;
  assign o_occupancy = r_occ;
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/endpoint_fifo.sv
// USB endpoint payload FIFO: byte storage, write-lane steering and read muxes.
// Word transfers are all-or-nothing and may straddle the wrap point in one cycle.
module endpoint_fifo
  import endpoint_fifo_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int WORD_BYTES = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int OCC_W  = PTR_W + 1,
  localparam int SIZE_W = $clog2(WORD_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    buffer_reserved,
  input  logic                    store_rx_packet_data,
  input  logic [7:0]              rx_packet_data,
  input  logic                    store_tx_data,
  input  logic [8*WORD_BYTES-1:0] tx_data,
  input  logic [SIZE_W-1:0]       data_size,
  input  logic                    get_rx_data,
  input  logic                    get_tx_packet_data,
  output logic [OCC_W-1:0]        buffer_occupancy,
  output logic [8*WORD_BYTES-1:0] rx_data,
  output logic [7:0]              tx_packet_data,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic                    underflow
);

  logic [7:0]       r_mem [DEPTH];
  logic [7:0]       r_tx_byte;
  logic             w_wr_tx, w_wr_rx, w_wr_req, w_wr_ok;
  logic             w_rd_tx, w_rd_req, w_rd_ok;
  logic [OCC_W-1:0] w_xfer_n, w_wr_n, w_rd_n;
  logic [PTR_W-1:0] w_wptr, w_rptr;

  // Only the owning write source is honoured; the other strobe is silently ignored.
  assign w_wr_tx  = buffer_reserved & store_tx_data;
  assign w_wr_rx  = ~buffer_reserved & store_rx_packet_data;
  assign w_wr_req = w_wr_tx | w_wr_rx;
  assign w_rd_tx  = get_tx_packet_data & ~get_rx_data;
  assign w_rd_req = get_rx_data | get_tx_packet_data;
  assign w_xfer_n = OCC_W'(bytes_of(4'(data_size)));
  assign w_wr_n   = w_wr_tx ? w_xfer_n : OCC_W'(1);
  assign w_rd_n   = get_rx_data ? w_xfer_n : OCC_W'(1);

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .OCC_W (OCC_W)
  ) u_ptr_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (clear),
    .i_wr_req    (w_wr_req),
    .i_wr_n      (w_wr_n),
    .i_rd_req    (w_rd_req),
    .i_rd_n      (w_rd_n),
    .o_wr_ok     (w_wr_ok),
    .o_rd_ok     (w_rd_ok),
    .o_wptr      (w_wptr),
    .o_rptr      (w_rptr),
    .o_occupancy (buffer_occupancy),
    .o_full      (full),
    .o_empty     (empty),
    .o_overflow  (overflow),
    .o_underflow (underflow)
  );

  always_ff @(posedge clk) begin
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (w_wr_ok && (w_wr_rx ? (k == 0) : (SIZE_W'(k) <= data_size))) begin
        r_mem[w_wptr + PTR_W'(k)] <= w_wr_rx ? rx_packet_data : tx_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_byte <= 8'h00;
    end else if (w_rd_ok && w_rd_tx) begin
      r_tx_byte <= r_mem[w_rptr];
    end
  end

  assign tx_packet_data = r_tx_byte;

  // Lanes beyond the requested size or the stored data read as zero.
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_rx_lane
    assign rx_data[8*gi +: 8] =
      ((SIZE_W'(gi) <= data_size) && (OCC_W'(gi) < buffer_occupancy))
        ? r_mem[w_rptr + PTR_W'(gi)] : 8'h00;
  end

endmodule

// File: tb/tb_endpoint_fifo.sv
// Self-checking bench: directed scenarios then random traffic against a queue model.
module tb_endpoint_fifo;

  localparam int DEPTH = 8;
  localparam int WB    = 4;

  logic        clk = 1'b0;
  logic        rst, clear, buffer_reserved;
  logic        store_rx_packet_data, store_tx_data, get_rx_data, get_tx_packet_data;
  logic [7:0]  rx_packet_data;
  logic [31:0] tx_data;
  logic [1:0]  data_size;
  logic [3:0]  buffer_occupancy;
  logic [31:0] rx_data;
  logic [7:0]  tx_packet_data;
  logic        full, empty, overflow, underflow;

  always #5 clk = ~clk;

  endpoint_fifo #(.DEPTH(DEPTH), .WORD_BYTES(WB)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .clear                (clear),
    .buffer_reserved      (buffer_reserved),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .data_size            (data_size),
    .get_rx_data          (get_rx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .rx_data              (rx_data),
    .tx_packet_data       (tx_packet_data),
    .full                 (full),
    .empty                (empty),
    .overflow             (overflow),
    .underflow            (underflow)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic       m_ov, m_un;
  logic [7:0] m_tx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] erx;
    erx = '0;
    for (int k = 0; k < WB; k++)
      if (k <= int'(data_size) && k < q.size()) erx[8*k +: 8] = q[k];
    chk("occupancy", 32'(buffer_occupancy), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
    chk("rx_data", rx_data, erx);
    chk("tx_packet_data", 32'(tx_packet_data), 32'(m_tx));
  endtask

  // One clock: drive inputs, advance the model from pre-edge state, compare after the edge.
  task automatic step(input logic i_rst, input logic i_clr, input logic br,
                      input logic srx, input logic [7:0] rxb,
                      input logic stx, input logic [31:0] txd, input logic [1:0] sz,
                      input logic grx, input logic gtx);
    int nw, nr;
    bit wr, rd, rdtx, wok, rok;
    rst = i_rst; clear = i_clr; buffer_reserved = br;
    store_rx_packet_data = srx; rx_packet_data = rxb;
    store_tx_data = stx; tx_data = txd; data_size = sz;
    get_rx_data = grx; get_tx_packet_data = gtx;
    nw = 0; nr = 0; wr = 0; rd = 0; rdtx = 0;
    if (i_rst || i_clr) begin
      q.delete();
      m_ov = 0;
      m_un = 0;
      if (i_rst) m_tx = 8'h00;
    end else begin
      if (br && stx) begin wr = 1; nw = int'(sz) + 1; end
      else if (!br && srx) begin wr = 1; nw = 1; end
      if (grx) begin rd = 1; nr = int'(sz) + 1; end
      else if (gtx) begin rd = 1; rdtx = 1; nr = 1; end
      wok = wr && (nw <= DEPTH - q.size());
      rok = rd && (nr <= q.size());
      if (wr && !wok) m_ov = 1;
      if (rd && !rok) m_un = 1;
      if (rok) begin
        if (rdtx) m_tx = q[0];
        repeat (nr) void'(q.pop_front());
      end
      if (wok)
        for (int k = 0; k < nw; k++) q.push_back((br && stx) ? txd[8*k +: 8] : rxb);
    end
    @(posedge clk);
    #1;
    check_model();
    rst = 0; clear = 0; store_rx_packet_data = 0; store_tx_data = 0;
    get_rx_data = 0; get_tx_packet_data = 0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    step(0, 0, 0, 1, b, 0, 32'h0, data_size, 0, 0);
  endtask

  task automatic pop_tx();
    step(0, 0, 0, 0, 8'h00, 0, 32'h0, data_size, 0, 1);
  endtask

  task automatic do_clear();
    step(0, 1, 0, 0, 8'h00, 0, 32'h0, data_size, 0, 0);
  endtask

  initial begin
    rst = 1; clear = 0; buffer_reserved = 0; store_rx_packet_data = 0; rx_packet_data = 0;
    store_tx_data = 0; tx_data = 0; data_size = 0; get_rx_data = 0; get_tx_packet_data = 0;
    q.delete(); m_ov = 0; m_un = 0; m_tx = 0;

    // Reset and simple RX push / TX pop ordering.
    step(1, 0, 0, 0, 8'h00, 0, 32'h0, 2'd0, 0, 0);
    chk("reset_empty", 32'(empty), 32'd1);
    push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
    pop_tx(); chk("tx_first", 32'(tx_packet_data), 32'h11);
    pop_tx(); chk("tx_second", 32'(tx_packet_data), 32'h22);
    pop_tx(); chk("tx_third", 32'(tx_packet_data), 32'h33);
    chk("empty_after_pops", 32'(empty), 32'd1);

    // Word write straddling the wrap point, then a word read.
    step(1, 0, 0, 0, 8'h00, 0, 32'h0, 2'd0, 0, 0);
    for (int i = 0; i < 6; i++) push_rx(8'(8'h40 + i));
    for (int i = 0; i < 6; i++) pop_tx();
    step(0, 0, 1, 0, 8'h00, 1, 32'hDDCCBBAA, 2'd3, 0, 0);
    chk("wrap_rx_data", rx_data, 32'hDDCCBBAA);
    step(0, 0, 1, 0, 8'h00, 0, 32'h0, 2'd3, 1, 0);
    chk("wrap_read_occ", 32'(buffer_occupancy), 32'd0);

    // Overflow on a word that does not fit, then clear.
    for (int i = 0; i < 6; i++) push_rx(8'(8'h60 + i));
    step(0, 0, 1, 0, 8'h00, 1, 32'h12345678, 2'd3, 0, 0);
    chk("ovf_occ", 32'(buffer_occupancy), 32'd6);
    chk("ovf_flag", 32'(overflow), 32'd1);
    do_clear();
    chk("clear_ovf", 32'(overflow), 32'd0);

    // Underflow on a two-byte read with one byte held.
    push_rx(8'h5A);
    step(0, 0, 0, 0, 8'h00, 0, 32'h0, 2'd1, 1, 0);
    chk("unf_occ", 32'(buffer_occupancy), 32'd1);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_upper_lanes", rx_data[31:8], 32'd0);

    // Concurrent push/pop against a full buffer and at mid occupancy.
    do_clear();
    for (int i = 0; i < DEPTH; i++) push_rx(8'(8'h80 + i));
    chk("full_flag", 32'(full), 32'd1);
    step(0, 0, 0, 1, 8'hEE, 0, 32'h0, 2'd0, 0, 1);
    chk("conc_full_occ", 32'(buffer_occupancy), 32'(DEPTH - 1));
    chk("conc_full_ovf", 32'(overflow), 32'd1);
    do_clear();
    for (int i = 0; i < 4; i++) push_rx(8'(8'hA0 + i));
    step(0, 0, 0, 1, 8'hEF, 0, 32'h0, 2'd0, 0, 1);
    chk("conc_mid_occ", 32'(buffer_occupancy), 32'd4);

    // Word read beats TX pop; clear beats a store.
    step(0, 0, 0, 0, 8'h00, 0, 32'h0, 2'd0, 1, 1);
    chk("prio_tx_hold", 32'(tx_packet_data), 32'hA0);
    chk("prio_occ", 32'(buffer_occupancy), 32'd3);
    step(0, 1, 1, 0, 8'h00, 1, 32'hCAFEF00D, 2'd3, 0, 0);
    chk("clear_prio_occ", 32'(buffer_occupancy), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
           1'($urandom), 1'($urandom), 8'($urandom),
           1'($urandom), 32'($urandom), 2'($urandom),
           $urandom_range(0, 3) == 0, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
